ov5640_sccb_ctrl: RTL and testbench



---
 rtl/ov5640_sccb_pkg.sv | 25 ++
 rtl/ov5640_sccb_ctrl_qtick.sv | 29 ++
 rtl/ov5640_sccb_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_ov5640_sccb_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_sccb_pkg.sv
// Shared types and constants for the OV5640 SCCB configuration sequencer.
// Holds the state encoding, status bit positions and bus framing sizes.
package ov5640_sccb_pkg;

  typedef enum logic [2:0] {
    PWR_DN,
    PWR_RST,
    IDLE,
    START,
    BYTE,
    STOP,
    DONE
  } state_t;

  localparam int ST_READY   = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_NACK    = 3;
  localparam int ST_OVERRUN = 4;

  localparam int SCCB_BYTES = 4;
  localparam int SCCB_BITS  = 9;
  localparam int QUARTERS   = 4;

endpackage

// File: rtl/ov5640_sccb_ctrl_qtick.sv
// Quarter-bit tick generator for the SCCB engine.
// Emits a one-cycle pulse every Q_DIV clocks while not held in clear.
module sccb_qtick #(
  parameter int Q_DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_qtick
);

  localparam int CW = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(Q_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_qtick = !i_clear && (r_cnt == TERM);

endmodule

// File: rtl/ov5640_sccb_ctrl.sv
// OV5640 camera configuration sequencer: power-up sequencing on PWDN/RSTN,
// then single-register SCCB 3-phase writes triggered by cfg_en rising edges.
module ov5640_sccb_ctrl
  import ov5640_sccb_pkg::*;
#(
  parameter int         CLK_FREQ    = 100_000_000,
  parameter int         SCCB_FREQ   = 100_000,
  parameter logic [7:0] DEV_ADDR    = 8'h78,
  parameter int         PWDN_CYCLES = 1_000_000,
  parameter int         RST_CYCLES  = 2_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_en,
  input  logic [31:0] i_cfg_da,
  input  logic        i_sda,
  output logic        o_scl_oe,
  output logic        o_sda_oe,
  output logic        o_cam_pwdn,
  output logic        o_cam_rstn,
  output logic [31:0] o_status
);

  localparam int Q_DIV   = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int PWR_MAX = (PWDN_CYCLES > RST_CYCLES) ? PWDN_CYCLES : RST_CYCLES;
  localparam int PW      = $clog2(PWR_MAX + 1);

  localparam logic [PW-1:0] PWDN_TERM = PW'(PWDN_CYCLES - 1);
  localparam logic [PW-1:0] RST_TERM  = PW'(RST_CYCLES - 1);
  localparam logic [3:0]    ACK_BIT   = 4'(SCCB_BITS - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(SCCB_BYTES - 1);
  localparam logic [1:0]    LAST_Q    = 2'(QUARTERS - 1);

  state_t        r_state;
  state_t        w_stateNext;
  logic [PW-1:0] r_pwrCnt;
  logic [1:0]    r_quarter;
  logic [3:0]    r_bit;
  logic [1:0]    r_byte;
  logic [15:0]   r_addr;
  logic [7:0]    r_data;
  logic [1:0]    r_sdaSync;
  logic          r_cfgEnQ;
  logic          r_pending;
  logic          r_done;
  logic          r_nack;
  logic          r_overrun;
  logic          r_sclOe;
  logic          r_sdaOe;
  logic          r_camPwdn;
  logic          r_camRstn;

  logic          w_req;
  logic          w_qtick;
  logic          w_xfer;
  logic          w_lastQ;
  logic          w_ackNack;
  logic          w_sclOe;
  logic          w_sdaOe;
  logic [7:0]    w_txByte;
  logic          w_txBit;
  logic          w_unusedBits;

  assign w_unusedBits = ^i_cfg_da[31:24];
  assign w_req        = i_cfg_en & ~r_cfgEnQ;
  assign w_xfer       = (r_state == START) || (r_state == BYTE) || (r_state == STOP);
  assign w_lastQ      = w_qtick && (r_quarter == LAST_Q);
  assign w_ackNack    = r_sdaSync[1];

  sccb_qtick #(
    .Q_DIV (Q_DIV)
  ) u_qtick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (!w_xfer),
    .o_qtick (w_qtick)
  );

  always_comb begin
    case (r_byte)
      2'd0:    w_txByte = DEV_ADDR;
      2'd1:    w_txByte = r_addr[15:8];
      2'd2:    w_txByte = r_addr[7:0];
      default: w_txByte = r_data;
    endcase
  end

  assign w_txBit = w_txByte[3'd7 - r_bit[2:0]];

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      PWR_DN:  if (r_pwrCnt == PWDN_TERM) w_stateNext = PWR_RST;
      PWR_RST: if (r_pwrCnt == RST_TERM) w_stateNext = IDLE;
      IDLE:    if (w_req || r_pending) w_stateNext = START;
      START:   if (w_lastQ) w_stateNext = BYTE;
      BYTE: begin
        if (w_lastQ && (r_bit == ACK_BIT) && (w_ackNack || (r_byte == LAST_BYTE)))
          w_stateNext = STOP;
      end
      STOP:    if (w_lastQ) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = PWR_DN;
    endcase
  end

  // Open-drain drive per quarter; released everywhere outside a transfer.
  always_comb begin
    w_sclOe = 1'b0;
    w_sdaOe = 1'b0;
    case (r_state)
      START: begin
        w_sclOe = (r_quarter == 2'd3);
        w_sdaOe = (r_quarter != 2'd0);
      end
      BYTE: begin
        w_sclOe = ~r_quarter[1];
        w_sdaOe = (r_bit != ACK_BIT) && !w_txBit;
      end
      STOP: begin
        w_sclOe = (r_quarter == 2'd0);
        w_sdaOe = ~r_quarter[1];
      end
      default: begin
        w_sclOe = 1'b0;
        w_sdaOe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= PWR_DN;
      r_pwrCnt  <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_sdaSync <= 2'b11;
      r_cfgEnQ  <= 1'b0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_nack    <= 1'b0;
      r_overrun <= 1'b0;
      r_sclOe   <= 1'b0;
      r_sdaOe   <= 1'b0;
      r_camPwdn <= 1'b1;
      r_camRstn <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cfgEnQ  <= i_cfg_en;
      r_sdaSync <= {r_sdaSync[0], i_sda};
      r_sclOe   <= w_sclOe;
      r_sdaOe   <= w_sdaOe;

      if (r_state == PWR_DN && r_pwrCnt == PWDN_TERM) begin
        r_camPwdn <= 1'b0;
        r_pwrCnt  <= '0;
      end else if (r_state == PWR_RST && r_pwrCnt == RST_TERM) begin
        r_camRstn <= 1'b1;
        r_pwrCnt  <= '0;
      end else if (r_state == PWR_DN || r_state == PWR_RST) begin
        r_pwrCnt <= r_pwrCnt + PW'(1);
      end

      // Requests before IDLE are parked until the power sequence finishes.
      if (w_req) begin
        if (r_state == PWR_DN || r_state == PWR_RST || r_state == IDLE) begin
          r_addr <= i_cfg_da[23:8];
          r_data <= i_cfg_da[7:0];
          if (r_state != IDLE) r_pending <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      if (r_state == IDLE && w_stateNext == START) begin
        r_pending <= 1'b0;
        r_done    <= 1'b0;
        r_nack    <= 1'b0;
      end

      if (r_state == BYTE && w_lastQ && r_bit == ACK_BIT && w_ackNack) r_nack <= 1'b1;
      if (r_state == STOP && w_lastQ) r_done <= 1'b1;

      if (r_state != w_stateNext) begin
        r_quarter <= '0;
        r_bit     <= '0;
        r_byte    <= '0;
      end else if (w_qtick) begin
        r_quarter <= r_quarter + 2'd1;
        if (r_state == BYTE && r_quarter == LAST_Q) begin
          if (r_bit == ACK_BIT) begin
            r_bit <= '0;
            if (r_byte != LAST_BYTE) r_byte <= r_byte + 2'd1;
          end else begin
            r_bit <= r_bit + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    o_status              = '0;
    o_status[ST_READY]    = (r_state == IDLE);
    o_status[ST_BUSY]     = w_xfer;
    o_status[ST_DONE]     = r_done;
    o_status[ST_NACK]     = r_nack;
    o_status[ST_OVERRUN]  = r_overrun;
  end

  assign o_scl_oe   = r_sclOe;
  assign o_sda_oe   = r_sdaOe;
  assign o_cam_pwdn = r_camPwdn;
  assign o_cam_rstn = r_camRstn;

endmodule

// File: tb/tb_ov5640_sccb_ctrl.sv
// Directed self-checking bench for ov5640_sccb_ctrl with an SCCB slave model
// that decodes START/STOP and bytes from the open-drain lines and ACKs or NACKs.
module tb_ov5640_sccb_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cfgEn;
  logic [31:0] cfgDa;
  logic        sclOe;
  logic        sdaOe;
  logic        camPwdn;
  logic        camRstn;
  logic [31:0] status;
  logic        slaveDrive = 1'b0;

  wire sclLine = ~sclOe;
  wire sdaLine = ~(sdaOe | slaveDrive);

  int compared   = 0;
  int mismatched = 0;

  int         bitCnt   = 0;
  int         byteIdx  = 0;
  int         nackByte = -1;
  int         startCnt = 0;
  int         stopCnt  = 0;
  logic [7:0] shiftReg = 8'h00;
  logic [7:0] rxBytes[$];
  logic       prevScl  = 1'b1;
  logic       prevSda  = 1'b1;

  always #5 clk = ~clk;

  ov5640_sccb_ctrl #(
    .CLK_FREQ    (4_000_000),
    .SCCB_FREQ   (100_000),
    .DEV_ADDR    (8'h78),
    .PWDN_CYCLES (20),
    .RST_CYCLES  (30)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_cfg_en   (cfgEn),
    .i_cfg_da   (cfgDa),
    .i_sda      (sdaLine),
    .o_scl_oe   (sclOe),
    .o_sda_oe   (sdaOe),
    .o_cam_pwdn (camPwdn),
    .o_cam_rstn (camRstn),
    .o_status   (status)
  );

  // Slave model: frames conditions, shifts bits on SCL rise, ACKs on the ninth slot.
  always @(negedge clk) begin
    if (!rstN) begin
      slaveDrive = 1'b0;
      bitCnt     = 0;
    end else if (prevScl && sclLine && prevSda && !sdaLine) begin
      startCnt++;
      bitCnt  = 0;
      byteIdx = 0;
    end else if (prevScl && sclLine && !prevSda && sdaLine) begin
      stopCnt++;
    end else if (!prevScl && sclLine) begin
      if (bitCnt < 8) shiftReg = {shiftReg[6:0], sdaLine};
      bitCnt++;
      if (bitCnt == 8) rxBytes.push_back(shiftReg);
    end else if (prevScl && !sclLine) begin
      if (bitCnt == 8) begin
        slaveDrive = (byteIdx != nackByte);
      end else if (bitCnt == 9) begin
        slaveDrive = 1'b0;
        bitCnt     = 0;
        byteIdx++;
      end
    end
    prevScl = sclLine;
    prevSda = sdaLine;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBytes(input string tag, input int n, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp[4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    checkOutput({tag, "_count"}, rxBytes.size(), n);
    for (int i = 0; i < n && i < rxBytes.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), rxBytes[i], exp[i]);
    checkOutput({tag, "_starts"}, startCnt, 1);
    checkOutput({tag, "_stops"}, stopCnt, 1);
  endtask

  // Waits (bounded) for the done bit; cycles are counted from the START-entry sample.
  task automatic waitDone(input bit overrunPoke, output int cycles, output logic [31:0] doneStatus);
    cycles = 0;
    while (status[2] !== 1'b1 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (overrunPoke && cycles == 400) begin
        cfgEn = 1'b0;
        cfgDa = 32'h0;
      end
      if (overrunPoke && cycles == 401) cfgEn = 1'b1;
    end
    doneStatus = status;
    cfgEn = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] da, input int nackAt, input bit overrunPoke,
                               output int cycles, output logic [31:0] doneStatus);
    rxBytes.delete();
    startCnt = 0;
    stopCnt  = 0;
    nackByte = nackAt;
    cfgDa    = da;
    cfgEn    = 1'b1;
    @(negedge clk);
    checkOutput("start_status", status, 32'h2);
    waitDone(overrunPoke, cycles, doneStatus);
  endtask

  initial begin
    int          cycles;
    logic [31:0] doneStatus;

    rstN  = 1'b0;
    cfgEn = 1'b0;
    cfgDa = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_status", status, 32'h0);
    checkOutput("rst_scl_oe", sclOe, 1'b0);
    checkOutput("rst_sda_oe", sdaOe, 1'b0);
    checkOutput("rst_pwdn", camPwdn, 1'b1);
    checkOutput("rst_rstn", camRstn, 1'b0);

    $display("[TB] power-up sequence");
    rstN = 1'b1;
    repeat (19) @(negedge clk);
    checkOutput("pwdn_c19", camPwdn, 1'b1);
    @(negedge clk);
    checkOutput("pwdn_c20", camPwdn, 1'b0);
    checkOutput("rstn_c20", camRstn, 1'b0);
    repeat (29) @(negedge clk);
    checkOutput("rstn_c49", camRstn, 1'b0);
    checkOutput("status_c49", status, 32'h0);
    @(negedge clk);
    checkOutput("rstn_c50", camRstn, 1'b1);
    checkOutput("status_idle", status, 32'h1);
    checkOutput("idle_scl_oe", sclOe, 1'b0);
    checkOutput("idle_sda_oe", sdaOe, 1'b0);

    $display("[TB] full write with ACKs");
    applyStimulus(32'h00300A56, -1, 1'b0, cycles, doneStatus);
    checkOutput("ack_cycles", cycles, 1520);
    checkOutput("ack_done_state", doneStatus, 32'h4);
    checkOutput("ack_status", status, 32'h5);
    checkBytes("ack", 4, 8'h78, 8'h30, 8'h0A, 8'h56);

    $display("[TB] NACK on second byte");
    applyStimulus(32'h00310B57, 1, 1'b0, cycles, doneStatus);
    checkOutput("nack_cycles", cycles, 800);
    checkOutput("nack_done_state", doneStatus, 32'hC);
    checkOutput("nack_status", status, 32'hD);
    checkBytes("nack", 2, 8'h78, 8'h31, 8'h00, 8'h00);

    $display("[TB] overrun request mid-transfer");
    applyStimulus(32'hFF123481, -1, 1'b1, cycles, doneStatus);
    checkOutput("ovr_cycles", cycles, 1520);
    checkOutput("ovr_status", status, 32'h15);
    checkBytes("ovr", 4, 8'h78, 8'h12, 8'h34, 8'h81);
    repeat (200) @(negedge clk);
    checkOutput("ovr_no_restart", startCnt, 1);
    checkOutput("ovr_status_late", status, 32'h15);

    $display("[TB] request during PWR_RST");
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (30) @(negedge clk);
    rxBytes.delete();
    startCnt = 0;
    stopCnt  = 0;
    nackByte = -1;
    cfgDa    = 32'h00AB01C3;
    cfgEn    = 1'b1;
    repeat (19) @(negedge clk);
    checkOutput("pend_c49", status, 32'h0);
    @(negedge clk);
    checkOutput("pend_idle", status, 32'h1);
    @(negedge clk);
    checkOutput("pend_start", status, 32'h2);
    waitDone(1'b0, cycles, doneStatus);
    checkOutput("pend_cycles", cycles, 1520);
    checkOutput("pend_status", status, 32'h5);
    checkBytes("pend", 4, 8'h78, 8'hAB, 8'h01, 8'hC3);

    $display("[TB] reset mid-byte");
    cfgDa = 32'h00300A56;
    cfgEn = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("mid_busy", status, 32'h2);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("mid_scl_oe", sclOe, 1'b0);
    checkOutput("mid_sda_oe", sdaOe, 1'b0);
    checkOutput("mid_pwdn", camPwdn, 1'b1);
    checkOutput("mid_rstn", camRstn, 1'b0);
    checkOutput("mid_status", status, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
